calc_sequencer: RTL

Key-driven control sequencer for the calculator datapath (input register, ALU mux, accumulator, opcode register, display mux). It accepts key events over a valid/ready handshake and produces one-cycle load/clear strobes plus the mux selects. It stretches ALU execution over a programmable number of cycles and traps ALU overflow in an error state. It replaces hand-driven opcode stimulus with a protocol-checked controller.

---
 rtl/calc_sequencer_if.sv | 19 +
 rtl/calc_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer_if.sv
// ============================================================================
// Module   : calc_sequencer_if
// Brief    : Key-event valid/ready handshake between key source and sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface calc_sequencer_if #(
  parameter int OPCODE_W = 3
) ();
  logic                key_valid;
  logic                key_ready;
  logic [OPCODE_W-1:0] key_code;

  modport master (output key_valid, output key_code, input  key_ready);
  modport slave  (input  key_valid, input  key_code, output key_ready);
endinterface

`default_nettype wire

// File: rtl/calc_sequencer.sv
// ============================================================================
// Module   : calc_sequencer
// Brief    : Key-driven control sequencer for the calculator datapath. Optional
//            2-entry key FIFO in front of the decoder: define CALC_KEY_QUEUE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_sequencer #(
  parameter int EXEC_CYCLES = 2,
  parameter int OPCODE_W    = 3
) (
  input  wire logic                clk,
  input  wire logic                reset,
  calc_sequencer_if.slave          key_if,
  input  wire logic                alu_ovf,
  output logic                     ld_number,
  output logic                     clear_number,
  output logic                     ld_opcode,
  output logic                     clear_opcode,
  output logic                     sel_a,
  output logic                     ld_result,
  output logic                     clear_result,
  output logic                     sel_display,
  output logic [OPCODE_W-1:0]      opcode_out,
  output logic                     busy,
  output logic                     error,
  output logic [5:0]               stage
);

  localparam logic [OPCODE_W-1:0] c_KEY_CLEAR = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] c_KEY_DIGIT = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] c_KEY_ENTER = OPCODE_W'(2);
  localparam logic [3:0]          c_EXEC_LAST = 4'(EXEC_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY_A = 3'd1,
    S_LOAD_A  = 3'd2,
    S_OP_WAIT = 3'd3,
    S_ENTRY_B = 3'd4,
    S_EXEC    = 3'd5,
    S_ERR     = 3'd6
  } state_t;

  state_t              r_state;
  logic                r_op_valid;
  logic [3:0]          r_cnt;
  logic [OPCODE_W-1:0] r_opcode;
  logic                r_key_ready;
  logic                r_ld_number;
  logic                r_clr_all;
  logic                r_ld_opcode;
  logic                r_ld_result;
  logic                r_sel_a;
  logic                r_sel_display;
  logic                r_busy;
  logic                r_error;
  logic [5:0]          r_stage;

  state_t              w_state_nxt;
  logic                w_op_valid_nxt;
  logic [3:0]          w_cnt_nxt;
  logic [OPCODE_W-1:0] w_opcode_nxt;
  logic                w_ld_number;
  logic                w_clr_all;
  logic                w_ld_opcode;
  logic                w_ld_result;
  logic                w_dec_valid;
  logic [OPCODE_W-1:0] w_dec_code;
  logic                w_ready_nxt;
  logic                w_is_operator;

  function automatic logic f_accepts(input state_t s);
    return !(s == S_LOAD_A || s == S_EXEC);
  endfunction

  // LOAD_A has no stage bit of its own and reports as ENTRY_A.
  function automatic logic [5:0] f_stage(input state_t s);
    case (s)
      S_IDLE:              return 6'b000001;
      S_ENTRY_A, S_LOAD_A: return 6'b000010;
      S_OP_WAIT:           return 6'b000100;
      S_ENTRY_B:           return 6'b001000;
      S_EXEC:              return 6'b010000;
      S_ERR:               return 6'b100000;
      default:             return 6'b000001;
    endcase
  endfunction

`ifdef CALC_KEY_QUEUE_EN
  logic [OPCODE_W-1:0] r_fifo [2];
  logic [1:0]          r_fifo_cnt;
  logic [OPCODE_W-1:0] w_fifo_nxt [2];
  logic [1:0]          w_fifo_cnt_nxt;
  logic                w_push;

  assign w_push      = key_if.key_valid & r_key_ready;
  assign w_dec_valid = (r_fifo_cnt != 2'd0) & f_accepts(r_state);
  assign w_dec_code  = r_fifo[0];
  assign w_ready_nxt = (w_fifo_cnt_nxt != 2'd2);

  // A decoded CLEAR flushes everything queued, including a key pushed now.
  always_comb begin
    w_fifo_nxt     = r_fifo;
    w_fifo_cnt_nxt = r_fifo_cnt;
    if (w_clr_all) begin
      w_fifo_cnt_nxt = 2'd0;
    end else begin
      if (w_dec_valid) begin
        w_fifo_nxt[0]  = r_fifo[1];
        w_fifo_cnt_nxt = w_fifo_cnt_nxt - 2'd1;
      end
      if (w_push) begin
        w_fifo_nxt[w_fifo_cnt_nxt[0]] = key_if.key_code;
        w_fifo_cnt_nxt                = w_fifo_cnt_nxt + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fifo_cnt <= 2'd0;
      r_fifo[0]  <= '0;
      r_fifo[1]  <= '0;
    end else begin
      r_fifo_cnt <= w_fifo_cnt_nxt;
      r_fifo[0]  <= w_fifo_nxt[0];
      r_fifo[1]  <= w_fifo_nxt[1];
    end
  end
`else
  assign w_dec_valid = key_if.key_valid & r_key_ready;
  assign w_dec_code  = key_if.key_code;
  assign w_ready_nxt = f_accepts(w_state_nxt);
`endif

  assign w_is_operator = w_dec_code[OPCODE_W-1];

  always_comb begin
    w_state_nxt    = r_state;
    w_op_valid_nxt = r_op_valid;
    w_opcode_nxt   = r_opcode;
    w_cnt_nxt      = r_cnt;
    w_ld_number    = 1'b0;
    w_clr_all      = 1'b0;
    w_ld_opcode    = 1'b0;
    w_ld_result    = 1'b0;
    case (r_state)
      S_LOAD_A: w_state_nxt = S_OP_WAIT;
      S_EXEC: begin
        // Overflow is only meaningful once the final result is being loaded.
        if (r_cnt == c_EXEC_LAST) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = alu_ovf ? S_ERR : S_OP_WAIT;
        end else begin
          w_cnt_nxt   = r_cnt + 4'd1;
          w_ld_result = ((r_cnt + 4'd1) == c_EXEC_LAST);
        end
      end
      default: begin
        if (w_dec_valid) begin
          if (w_dec_code == c_KEY_CLEAR) begin
            w_clr_all      = 1'b1;
            w_op_valid_nxt = 1'b0;
            w_opcode_nxt   = '0;
            w_state_nxt    = S_IDLE;
          end else begin
            case (r_state)
              S_IDLE: begin
                if (w_dec_code == c_KEY_DIGIT) begin
                  w_ld_number = 1'b1;
                  w_state_nxt = S_ENTRY_A;
                end
              end
              S_ENTRY_A: begin
                if (w_dec_code == c_KEY_DIGIT) begin
                  w_ld_number = 1'b1;
                end else if (w_dec_code == c_KEY_ENTER) begin
                  w_ld_result = 1'b1;
                  w_state_nxt = S_LOAD_A;
                end
              end
              S_OP_WAIT: begin
                if (w_is_operator) begin
                  w_opcode_nxt   = w_dec_code;
                  w_op_valid_nxt = 1'b1;
                  w_ld_opcode    = 1'b1;
                end else if (w_dec_code == c_KEY_ENTER && r_op_valid) begin
                  w_state_nxt = S_ENTRY_B;
                end
              end
              S_ENTRY_B: begin
                if (w_dec_code == c_KEY_DIGIT) begin
                  w_ld_number = 1'b1;
                end else if (w_dec_code == c_KEY_ENTER) begin
                  w_cnt_nxt   = 4'd1;
                  w_ld_result = (c_EXEC_LAST == 4'd1);
                  w_state_nxt = S_EXEC;
                end
              end
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  // Every output is a flop loaded from the next-state decode.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_op_valid    <= 1'b0;
      r_cnt         <= 4'd0;
      r_opcode      <= '0;
      r_key_ready   <= 1'b1;
      r_ld_number   <= 1'b0;
      r_clr_all     <= 1'b0;
      r_ld_opcode   <= 1'b0;
      r_ld_result   <= 1'b0;
      r_sel_a       <= 1'b0;
      r_sel_display <= 1'b0;
      r_busy        <= 1'b0;
      r_error       <= 1'b0;
      r_stage       <= 6'b000001;
    end else begin
      r_state       <= w_state_nxt;
      r_op_valid    <= w_op_valid_nxt;
      r_cnt         <= w_cnt_nxt;
      r_opcode      <= w_opcode_nxt;
      r_key_ready   <= w_ready_nxt;
      r_ld_number   <= w_ld_number;
      r_clr_all     <= w_clr_all;
      r_ld_opcode   <= w_ld_opcode;
      r_ld_result   <= w_ld_result;
      r_sel_a       <= (w_state_nxt == S_EXEC);
      r_sel_display <= (w_state_nxt == S_OP_WAIT) || (w_state_nxt == S_EXEC) ||
                       (w_state_nxt == S_ERR);
      r_busy        <= !f_accepts(w_state_nxt);
      r_error       <= (w_state_nxt == S_ERR);
      r_stage       <= f_stage(w_state_nxt);
    end
  end

  assign key_if.key_ready = r_key_ready;
  assign ld_number        = r_ld_number;
  assign clear_number     = r_clr_all;
  assign ld_opcode        = r_ld_opcode;
  assign clear_opcode     = r_clr_all;
  assign sel_a            = r_sel_a;
  assign ld_result        = r_ld_result;
  assign clear_result     = r_clr_all;
  assign sel_display      = r_sel_display;
  assign opcode_out       = r_opcode;
  assign busy             = r_busy;
  assign error            = r_error;
  assign stage            = r_stage;

endmodule

`default_nettype wire
